// File: rtl/wb8_xbar_pkg.sv
// wb8_xbar_pkg: shared state encoding, error data and index-width helper for the wb8_xbar crossbar.
package wb8_xbar_pkg;

   typedef enum logic {
      WB8_XBAR_IDLE,
      WB8_XBAR_BUSY
   } state_t;

   localparam logic [7:0] WB8_XBAR_ERR_DAT = 8'hFF;

   function automatic int sel_width(int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb8_xbar_if.sv
// wb8_xbar_if: master-side Wishbone-8 bus plus the per-slave fan-out of the crossbar.
interface wb8_xbar_if #(parameter int NSLAVES = 2);
   logic                   I_wb_stb;
   logic                   I_wb_we;
   logic [31:0]            I_wb_adr;
   logic [7:0]             I_wb_dat;
   logic [7:0]             O_wb_dat;
   logic                   O_wb_ack;
   logic                   O_wb_stall;
   logic [NSLAVES-1:0]     O_s_stb;
   logic                   O_s_we;
   logic [31:0]            O_s_adr;
   logic [7:0]             O_s_dat;
   logic [8*NSLAVES-1:0]   I_s_dat;
   logic [NSLAVES-1:0]     I_s_ack;
   logic [NSLAVES-1:0]     I_s_stall;
   logic                   O_err;
   logic [31:0]            O_err_adr;

   modport slave (
      input  I_wb_stb, I_wb_we, I_wb_adr, I_wb_dat, I_s_dat, I_s_ack, I_s_stall,
      output O_wb_dat, O_wb_ack, O_wb_stall, O_s_stb, O_s_we, O_s_adr, O_s_dat, O_err, O_err_adr
   );

   modport master (
      output I_wb_stb, I_wb_we, I_wb_adr, I_wb_dat, I_s_dat, I_s_ack, I_s_stall,
      input  O_wb_dat, O_wb_ack, O_wb_stall, O_s_stb, O_s_we, O_s_adr, O_s_dat, O_err, O_err_adr
   );
endinterface

// File: rtl/wb8_xbar_decode.sv
// wb8_xbar_decode: combinational priority matcher of the top address bits; lowest matching slave wins.
module wb8_xbar_decode
   import wb8_xbar_pkg::*;
#(
   parameter int                          NSLAVES       = 2,
   parameter int                          SELBITS       = 4,
   parameter logic [NSLAVES*SELBITS-1:0]  SLAVE_BASE    = {4'hF, 4'h0},
   parameter int                          DEFAULT_SLAVE = 0,
   parameter int                          SW            = sel_width(NSLAVES)
) (
   input  logic [SELBITS-1:0] I_adr,
   output logic [SW-1:0]      O_sel
);

   always_comb begin
      O_sel = SW'(DEFAULT_SLAVE);
      for (int i = NSLAVES - 1; i >= 0; i--)
         if (I_adr == SLAVE_BASE[i*SELBITS +: SELBITS]) O_sel = SW'(i);
   end

endmodule

// File: rtl/wb8_xbar.sv
// wb8_xbar: single-master Wishbone-8 pipelined interconnect to NSLAVES slaves.
// Define WB8_XBAR_TIMEOUT_EN to terminate hung transfers with an error ack after TIMEOUT cycles.
module wb8_xbar
   import wb8_xbar_pkg::*;
#(
   parameter int                          NSLAVES       = 2,
   parameter int                          SELBITS       = 4,
   parameter logic [NSLAVES*SELBITS-1:0]  SLAVE_BASE    = {4'hF, 4'h0},
   parameter int                          DEFAULT_SLAVE = 0,
   parameter int                          TIMEOUT       = 255
) (
   input logic          I_wb_clk,
   input logic          I_reset,
   wb8_xbar_if.slave    bus
);

   localparam int SW = sel_width(NSLAVES);

   state_t        state;
   logic [SW-1:0] sel;
   logic [SW-1:0] resp_sel;
   logic          busy;
   logic          s_ack;
   logic          open;
   logic          accept;
   logic          tmo;

   wb8_xbar_decode #(
      .NSLAVES       (NSLAVES),
      .SELBITS       (SELBITS),
      .SLAVE_BASE    (SLAVE_BASE),
      .DEFAULT_SLAVE (DEFAULT_SLAVE),
      .SW            (SW)
   ) u_decode (
      .I_adr (bus.I_wb_adr[31 -: SELBITS]),
      .O_sel (sel)
   );

   // The request path is open when idle or in the ack cycle, allowing back-to-back transfers.
   assign busy           = state == WB8_XBAR_BUSY;
   assign s_ack          = busy && bus.I_s_ack[resp_sel];
   assign open           = !busy || s_ack;
   assign bus.O_s_stb    = (!I_reset && open && bus.I_wb_stb) ? NSLAVES'(1) << sel : '0;
   assign bus.O_wb_stall = I_reset || !open || bus.I_s_stall[sel];
   assign accept         = bus.I_wb_stb && !bus.O_wb_stall;
   assign bus.O_wb_ack   = !I_reset && (s_ack || tmo);
   assign bus.O_wb_dat   = I_reset ? 8'h00 :
                           s_ack   ? bus.I_s_dat[{resp_sel, 3'b000} +: 8] :
                           tmo     ? WB8_XBAR_ERR_DAT : 8'h00;
   assign bus.O_s_we     = bus.I_wb_we;
   assign bus.O_s_adr    = bus.I_wb_adr;
   assign bus.O_s_dat    = bus.I_wb_dat;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         state    <= WB8_XBAR_IDLE;
         resp_sel <= '0;
      end else if (tmo) begin
         state    <= WB8_XBAR_IDLE;
      end else if (accept) begin
         state    <= WB8_XBAR_BUSY;
         resp_sel <= sel;
      end else if (s_ack) begin
         state    <= WB8_XBAR_IDLE;
      end
   end

`ifdef WB8_XBAR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic [31:0]   cur_adr;
   logic [31:0]   err_adr;
   logic          err;

   // cnt holds the completed ack-less BUSY cycles, so the TIMEOUT-th one fires the error.
   assign tmo           = busy && !s_ack && cnt == CW'(TIMEOUT - 1);
   assign bus.O_err     = err;
   assign bus.O_err_adr = err_adr;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         cnt     <= '0;
         cur_adr <= '0;
         err     <= 1'b0;
         err_adr <= '0;
      end else begin
         err <= tmo;
         if (tmo) err_adr <= cur_adr;
         if (accept) begin
            cnt     <= '0;
            cur_adr <= bus.I_wb_adr;
         end else if (busy && !s_ack && cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   assign tmo           = 1'b0;
   assign bus.O_err     = 1'b0;
   assign bus.O_err_adr = '0;
`endif

endmodule

// File: tb/tb_wb8_xbar.sv
// tb_wb8_xbar: directed and randomized checks of wb8_xbar against a transaction-level reference model.
module tb_wb8_xbar;

   localparam int N  = 2;
   localparam int TO = 8;
`ifdef WB8_XBAR_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb8_xbar_if #(.NSLAVES(N)) bus ();

   wb8_xbar #(
      .NSLAVES       (N),
      .SELBITS       (4),
      .SLAVE_BASE    (8'hF0),
      .DEFAULT_SLAVE (0),
      .TIMEOUT       (TO)
   ) dut (
      .I_wb_clk (clk),
      .I_reset  (rst),
      .bus      (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          base [N] = '{0, 15};
   bit          pending;
   bit          err_q;
   int          ps;
   int          acc_cyc;
   int          cyc = 0;
   logic [31:0] cur;
   logic [31:0] err_adr_q;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int dec(logic [31:0] a);
      for (int i = 0; i < N; i++)
         if (int'(a[31:28]) == base[i]) return i;
      return 0;
   endfunction

   // One clock: compare every output with the model, advance the model, cross the edge.
   task automatic step();
      int sel;
      bit sack, tmo, free;
      logic [7:0] edat;
      #1;
      sel = dec(bus.I_wb_adr);
      chk("bc_adr", bus.O_s_adr, bus.I_wb_adr);
      chk("bc_wedat", {bus.O_s_we, bus.O_s_dat}, {bus.I_wb_we, bus.I_wb_dat});
      if (rst) begin
         chk("rst_stb", bus.O_s_stb, 0);
         chk("rst_stall", bus.O_wb_stall, 1);
         chk("rst_ack", bus.O_wb_ack, 0);
         pending   = 0;
         err_q     = 0;
         err_adr_q = 0;
      end else begin
         sack = pending && bus.I_s_ack[ps];
         tmo  = TMO_EN && pending && !sack && (cyc - acc_cyc == TO);
         free = !pending || sack;
         edat = sack ? bus.I_s_dat[ps*8 +: 8] : tmo ? 8'hFF : 8'h00;
         chk("stb", bus.O_s_stb, (free && bus.I_wb_stb) ? (1 << sel) : 0);
         chk("stall", bus.O_wb_stall, !free || bus.I_s_stall[sel]);
         chk("ack", bus.O_wb_ack, sack || tmo);
         chk("dat", bus.O_wb_dat, edat);
         chk("err", bus.O_err, err_q);
         chk("err_adr", bus.O_err_adr, err_adr_q);
         err_q = tmo;
         if (tmo) begin
            err_adr_q = cur;
            pending   = 0;
         end else if (free && bus.I_wb_stb && !bus.I_s_stall[sel]) begin
            pending = 1;
            ps      = sel;
            cur     = bus.I_wb_adr;
            acc_cyc = cyc;
         end else if (sack) begin
            pending = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit stb, logic [31:0] adr, logic [1:0] ack, logic [1:0] stall);
      bus.I_wb_stb  = stb;
      bus.I_wb_adr  = adr;
      bus.I_s_ack   = ack;
      bus.I_s_stall = stall;
   endtask

   initial begin
      int acks, errs;
      rst = 1;
      bus.I_wb_we  = 0;
      bus.I_wb_dat = 8'h00;
      bus.I_s_dat  = 16'h0000;
      drive(0, 0, 0, 0);
      @(posedge clk);
      #1;
      step();
      step();
      rst = 0;

      // Decode
      drive(1, 32'h0000_0010, 0, 0);
      #1 chk("dec_slave0", bus.O_s_stb, 2'b01);
      step();
      drive(0, 0, 2'b01, 0);
      bus.I_s_dat = 16'h2211;
      step();
      drive(1, 32'hF000_0000, 0, 0);
      #1 chk("dec_slave1", bus.O_s_stb, 2'b10);
      step();
      drive(0, 0, 2'b10, 0);
      #1 chk("dec_slave1_dat", bus.O_wb_dat, 8'h22);
      step();
      drive(1, 32'h3000_0000, 0, 0);
      #1 chk("dec_default", bus.O_s_stb, 2'b01);
      step();
      drive(0, 0, 2'b01, 0);
      step();

      // Stall
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h0000_0020, 0, 2'b01);
         #1 chk("stall_hold", bus.O_wb_stall, 1);
         step();
      end
      drive(1, 32'h0000_0020, 0, 0);
      #1 chk("stall_release", {bus.O_wb_stall, bus.O_s_stb}, 3'b001);
      step();
      drive(1, 32'h0000_0020, 0, 0);
      #1 chk("busy_no_stb", bus.O_s_stb, 0);
      step();
      drive(0, 0, 2'b01, 0);
      step();

      // Pipelined re-route
      drive(1, 32'h0000_0000, 0, 0);
      step();
      drive(1, 32'hF000_0004, 2'b01, 0);
      bus.I_s_dat = 16'h335A;
      #1 chk("reroute_dat", bus.O_wb_dat, 8'h5A);
      chk("reroute_accept", {bus.O_wb_stall, bus.O_s_stb}, 3'b010);
      step();
      drive(0, 0, 2'b10, 0);
      #1 chk("reroute_dat2", bus.O_wb_dat, 8'h33);
      step();

      // Spurious acks
      drive(0, 0, 2'b10, 0);
      #1 chk("spur_idle", bus.O_wb_ack, 0);
      step();
      drive(1, 32'h0000_0000, 2'b10, 0);
      step();
      drive(0, 0, 2'b10, 0);
      #1 chk("spur_busy", {bus.O_wb_ack, bus.O_wb_dat}, 9'h000);
      step();
      drive(0, 0, 2'b01, 0);
      step();

      // Hung slave
      drive(1, 32'h0000_0ABC, 0, 0);
      step();
      acks = 0;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0);
         #1;
         acks += int'(bus.O_wb_ack);
         errs += int'(bus.O_err);
         step();
      end
      chk("hang_acks", acks, TMO_EN ? 1 : 0);
      chk("hang_errs", errs, TMO_EN ? 1 : 0);
      chk("hang_err_adr", bus.O_err_adr, TMO_EN ? 32'h0000_0ABC : 0);
      drive(0, 0, 2'b01, 0);
      step();

      // Reset mid-BUSY
      drive(1, 32'h0000_0000, 0, 0);
      step();
      drive(0, 0, 0, 0);
      rst = 1;
      #1 chk("rst_busy_stall", bus.O_wb_stall, 1);
      step();
      rst = 0;
      drive(0, 0, 2'b01, 0);
      #1 chk("rst_late_ack", bus.O_wb_ack, 0);
      step();
      drive(1, 32'hF000_0000, 0, 0);
      step();
      drive(0, 0, 2'b10, 0);
      bus.I_s_dat = 16'hC300;
      #1 chk("post_rst_xfer", {bus.O_wb_ack, bus.O_wb_dat}, 9'h1C3);
      step();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] top;
         case ($urandom_range(3))
            0: top = 4'h0;
            1: top = 4'hF;
            2: top = 4'h3;
            default: top = 4'($urandom);
         endcase
         rst           = ($urandom_range(63) == 0);
         bus.I_wb_stb  = ($urandom_range(3) != 0);
         bus.I_wb_we   = 1'($urandom);
         bus.I_wb_adr  = {top, 28'($urandom)};
         bus.I_wb_dat  = 8'($urandom);
         bus.I_s_dat   = 16'($urandom);
         bus.I_s_ack   = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
         bus.I_s_stall = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
